// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: unit codes, ALU opcodes, tag width and station control layout.
package tomasulo_pkg;

  localparam logic [2:0] UNIT_ADDER = 3'b000;

  localparam int unsigned TAG_W = 6;
  typedef logic [TAG_W-1:0] tag_t;
  localparam tag_t TAG_NONE = '0;

  // Low opcode bits select the ALU function; upper bits are ignored by the adder unit.
  localparam logic [5:0] OP_ALU_MASK = 6'b000111;

  typedef enum logic [2:0] {
    AluAdd = 3'b000,
    AluSub = 3'b001,
    AluOr  = 3'b100,
    AluAnd = 3'b101,
    AluNot = 3'b110,
    AluXor = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic       busy;
    logic       exec;
    logic [2:0] op;
    logic [4:0] dest;
    tag_t       qj;
    tag_t       qk;
  } rs_ctrl_t;

  function automatic tag_t tag_of(int idx);
    return tag_t'(idx + 1);
  endfunction

endpackage

// File: rtl/adder_rs_if.sv
// Issue/status/CDB interface between the instruction queue (master) and the adder station (slave).
interface adder_rs_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  issue;
  logic [5:0]            operation;
  logic [2:0]            execution_unit;
  logic [4:0]            Dest_address;
  logic [4:0]            A_address;
  logic [4:0]            B_address;
  logic [DATA_WIDTH-1:0] A_value;
  logic [DATA_WIDTH-1:0] B_value;
  logic                  adder_available;
  logic [5:0]            adder_RS_available;
  logic                  issue_error;
  logic [5:0]            RS_issued;
  logic [5:0]            RS_executing_adder;
  logic                  adder_rts;
  logic [5:0]            RS_finished;
  logic [DATA_WIDTH-1:0] result_value;
  logic                  wb_enable;
  logic [4:0]            wb_address;

  modport master (
    output issue, operation, execution_unit, Dest_address, A_address, B_address, A_value, B_value,
    input  adder_available, adder_RS_available, issue_error, RS_issued, RS_executing_adder,
    input  adder_rts, RS_finished, result_value, wb_enable, wb_address
  );

  modport slave (
    input  issue, operation, execution_unit, Dest_address, A_address, B_address, A_value, B_value,
    output adder_available, adder_RS_available, issue_error, RS_issued, RS_executing_adder,
    output adder_rts, RS_finished, result_value, wb_enable, wb_address
  );
endinterface

// File: rtl/adder_alu.sv
// Combinational integer ALU shared by the adder unit; unlisted opcodes return zero.
module adder_alu
  import tomasulo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [2:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_result
);
  always_comb begin
    o_result = '0;
    case (alu_op_e'(i_op))
      AluAdd:  o_result = i_a + i_b;
      AluSub:  o_result = i_a - i_b;
      AluOr:   o_result = i_a | i_b;
      AluAnd:  o_result = i_a & i_b;
      AluNot:  o_result = ~i_a;
      AluXor:  o_result = i_a ^ i_b;
      default: o_result = '0;
    endcase
  end
endmodule

// File: rtl/adder_reservation_station.sv
// Adder reservation stations with register renaming, one non-pipelined adder and CDB broadcast.
// Optional statistics counters are built when RS_STATS_EN is defined.
module adder_reservation_station
  import tomasulo_pkg::*;
#(
  parameter int unsigned NUM_RS      = 3,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_REGS    = 32,
  parameter int unsigned ADD_LATENCY = 2
) (
  input logic       clock,
  input logic       reset,
  adder_rs_if.slave bus
`ifdef RS_STATS_EN
  ,
  output logic [15:0] stat_issued,
  output logic [15:0] stat_rejected,
  output logic [15:0] stat_stall_cycles
`endif
);
  localparam int unsigned CNT_W = $clog2(ADD_LATENCY + 1);

  rs_ctrl_t              r_ctrl   [NUM_RS];
  logic [DATA_WIDTH-1:0] r_vj     [NUM_RS];
  logic [DATA_WIDTH-1:0] r_vk     [NUM_RS];
  tag_t                  r_status [NUM_REGS];

  logic                  r_add_busy;
  logic [CNT_W-1:0]      r_cnt;
  tag_t                  r_ex_tag;
  logic [2:0]            r_ex_op;
  logic [4:0]            r_ex_dest;
  logic [DATA_WIDTH-1:0] r_ex_a, r_ex_b;

  logic                  r_issue_error, r_rts;
  tag_t                  r_rs_issued, r_rs_exec, r_finished;
  logic [DATA_WIDTH-1:0] r_result;
  logic [4:0]            r_wb_address;

  logic [NUM_RS-1:0]     w_free, w_ready, w_alloc_oh, w_disp_oh;
  tag_t                  w_alloc_tag, w_disp_tag, w_qa, w_qb;
  logic                  w_complete, w_dispatch, w_issue_ok, w_issue_err;
  logic [DATA_WIDTH-1:0] w_cdb_value, w_va, w_vb, w_disp_a, w_disp_b;
  logic [2:0]            w_disp_op;
  logic [4:0]            w_disp_dest;
  logic [5:0]            w_op_masked;
  logic                  w_unused_op;

  always_comb begin
    for (int i = 0; i < NUM_RS; i++) begin
      w_free[i]  = !r_ctrl[i].busy;
      w_ready[i] = r_ctrl[i].busy && !r_ctrl[i].exec &&
                   (r_ctrl[i].qj == TAG_NONE) && (r_ctrl[i].qk == TAG_NONE);
    end
  end

  // Isolate the lowest set bit: lowest free station and lowest ready station.
  assign w_alloc_oh = w_free & (~w_free + NUM_RS'(1));
  assign w_disp_oh  = w_ready & (~w_ready + NUM_RS'(1));

  always_comb begin
    w_alloc_tag = TAG_NONE;
    w_disp_tag  = TAG_NONE;
    w_disp_op   = '0;
    w_disp_dest = '0;
    w_disp_a    = '0;
    w_disp_b    = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (w_alloc_oh[i]) w_alloc_tag = tag_of(i);
      if (w_disp_oh[i]) begin
        w_disp_tag  = tag_of(i);
        w_disp_op   = r_ctrl[i].op;
        w_disp_dest = r_ctrl[i].dest;
        w_disp_a    = r_vj[i];
        w_disp_b    = r_vk[i];
      end
    end
  end

  assign w_complete  = r_add_busy && (r_cnt == CNT_W'(1));
  assign w_dispatch  = !r_add_busy && (|w_ready);
  assign w_issue_ok  = bus.issue && (bus.execution_unit == UNIT_ADDER) && (|w_free);
  assign w_issue_err = bus.issue && !w_issue_ok;
  assign w_op_masked = bus.operation & OP_ALU_MASK;
  assign w_unused_op = ^w_op_masked[5:3];

  adder_alu #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu (
    .i_op     (r_ex_op),
    .i_a      (r_ex_a),
    .i_b      (r_ex_b),
    .o_result (w_cdb_value)
  );

  // A source whose producer broadcasts on this very edge is taken straight off the CDB.
  always_comb begin
    w_qa = r_status[bus.A_address];
    w_va = bus.A_value;
    if (w_qa != TAG_NONE) begin
      w_va = '0;
      if (w_complete && (w_qa == r_ex_tag)) begin
        w_va = w_cdb_value;
        w_qa = TAG_NONE;
      end
    end
    w_qb = r_status[bus.B_address];
    w_vb = bus.B_value;
    if (w_qb != TAG_NONE) begin
      w_vb = '0;
      if (w_complete && (w_qb == r_ex_tag)) begin
        w_vb = w_cdb_value;
        w_qb = TAG_NONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_RS; i++) begin
        r_ctrl[i] <= '0;
        r_vj[i]   <= '0;
        r_vk[i]   <= '0;
      end
      for (int r = 0; r < NUM_REGS; r++) r_status[r] <= TAG_NONE;
      r_add_busy    <= 1'b0;
      r_cnt         <= '0;
      r_ex_tag      <= TAG_NONE;
      r_ex_op       <= '0;
      r_ex_dest     <= '0;
      r_ex_a        <= '0;
      r_ex_b        <= '0;
      r_issue_error <= 1'b0;
      r_rs_issued   <= TAG_NONE;
      r_rs_exec     <= TAG_NONE;
      r_rts         <= 1'b0;
      r_finished    <= TAG_NONE;
      r_result      <= '0;
      r_wb_address  <= '0;
    end else begin
      r_issue_error <= w_issue_err;
      r_rs_issued   <= w_issue_ok ? w_alloc_tag : TAG_NONE;
      r_rs_exec     <= w_dispatch ? w_disp_tag : TAG_NONE;
      r_rts         <= w_complete;
      r_finished    <= w_complete ? r_ex_tag : TAG_NONE;
      r_result      <= w_complete ? w_cdb_value : '0;
      r_wb_address  <= w_complete ? r_ex_dest : '0;

      for (int i = 0; i < NUM_RS; i++) begin
        if (w_complete && (r_ex_tag == tag_of(i))) begin
          r_ctrl[i].busy <= 1'b0;
          r_ctrl[i].exec <= 1'b0;
        end else if (w_complete && r_ctrl[i].busy) begin
          if (r_ctrl[i].qj == r_ex_tag) begin
            r_vj[i]      <= w_cdb_value;
            r_ctrl[i].qj <= TAG_NONE;
          end
          if (r_ctrl[i].qk == r_ex_tag) begin
            r_vk[i]      <= w_cdb_value;
            r_ctrl[i].qk <= TAG_NONE;
          end
        end
        if (w_dispatch && w_disp_oh[i]) r_ctrl[i].exec <= 1'b1;
        if (w_issue_ok && w_alloc_oh[i]) begin
          r_ctrl[i] <= '{busy: 1'b1, exec: 1'b0, op: bus.operation[2:0],
                         dest: bus.Dest_address, qj: w_qa, qk: w_qb};
          r_vj[i]   <= w_va;
          r_vk[i]   <= w_vb;
        end
      end

      // The issue write comes last so a new rename of the same register wins.
      if (w_complete && (r_status[r_ex_dest] == r_ex_tag)) r_status[r_ex_dest] <= TAG_NONE;
      if (w_issue_ok) r_status[bus.Dest_address] <= w_alloc_tag;

      if (w_dispatch) begin
        r_add_busy <= 1'b1;
        r_cnt      <= CNT_W'(ADD_LATENCY);
        r_ex_tag   <= w_disp_tag;
        r_ex_op    <= w_disp_op;
        r_ex_dest  <= w_disp_dest;
        r_ex_a     <= w_disp_a;
        r_ex_b     <= w_disp_b;
      end else if (r_add_busy) begin
        r_cnt <= r_cnt - CNT_W'(1);
        if (w_complete) r_add_busy <= 1'b0;
      end
    end
  end

  assign bus.adder_available    = |w_free;
  assign bus.adder_RS_available = w_alloc_tag;
  assign bus.issue_error        = r_issue_error;
  assign bus.RS_issued          = r_rs_issued;
  assign bus.RS_executing_adder = r_rs_exec;
  assign bus.adder_rts          = r_rts;
  assign bus.RS_finished        = r_finished;
  assign bus.result_value       = r_result;
  assign bus.wb_enable          = r_rts;
  assign bus.wb_address         = r_wb_address;

`ifdef RS_STATS_EN
  logic        w_stall;
  logic [15:0] r_stat_issued, r_stat_rejected, r_stat_stall;

  always_comb begin
    w_stall = 1'b0;
    for (int i = 0; i < NUM_RS; i++) begin
      w_stall = w_stall || (r_ctrl[i].busy &&
                ((r_ctrl[i].qj != TAG_NONE) || (r_ctrl[i].qk != TAG_NONE)));
    end
    w_stall = w_stall && !r_add_busy;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stat_issued   <= '0;
      r_stat_rejected <= '0;
      r_stat_stall    <= '0;
    end else begin
      if (w_issue_ok && (r_stat_issued != 16'hFFFF)) r_stat_issued <= r_stat_issued + 16'd1;
      if (w_issue_err && (r_stat_rejected != 16'hFFFF)) r_stat_rejected <= r_stat_rejected + 16'd1;
      if (w_stall && (r_stat_stall != 16'hFFFF)) r_stat_stall <= r_stat_stall + 16'd1;
    end
  end

  assign stat_issued       = r_stat_issued;
  assign stat_rejected     = r_stat_rejected;
  assign stat_stall_cycles = r_stat_stall;
`endif

endmodule

// File: tb/tb_adder_reservation_station.sv
// Self-checking bench: directed scenarios plus random issue traffic against a Tomasulo reference model.
module tb_adder_reservation_station;
  localparam int NRS = 3;
  localparam int LAT = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  adder_rs_if #(.DATA_WIDTH(32)) bus ();

  adder_reservation_station #(
    .NUM_RS      (NRS),
    .DATA_WIDTH  (32),
    .NUM_REGS    (32),
    .ADD_LATENCY (LAT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Reference model: stations, rename table and adder tracked as cycle numbers.
  int          m_busy [NRS], m_exec [NRS], m_op [NRS], m_dest [NRS], m_qj [NRS], m_qk [NRS];
  logic [31:0] m_vj [NRS], m_vk [NRS];
  int          m_stat [32];
  int          m_add_busy, m_done, m_tag, m_exdest, k;
  logic [31:0] m_res;
  int          e_err, e_iss, e_exe, e_rts, e_fin, e_wb, e_avail, e_rsav;
  logic [31:0] e_res;
  int          last_fin, seen_rts;
  logic [31:0] last_res;

  function automatic logic [31:0] alu(int op, logic [31:0] a, logic [31:0] b);
    case (op)
      0: return a + b;
      1: return a - b;
      4: return a | b;
      5: return a & b;
      6: return ~a;
      7: return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_outputs();
    e_avail = 0;
    e_rsav  = 0;
    for (int i = NRS - 1; i >= 0; i--) begin
      if (m_busy[i] == 0) begin
        e_avail = 1;
        e_rsav  = i + 1;
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NRS; i++) begin
      m_busy[i] = 0; m_exec[i] = 0; m_qj[i] = 0; m_qk[i] = 0;
    end
    for (int r = 0; r < 32; r++) m_stat[r] = 0;
    m_add_busy = 0; k = 0;
    e_err = 0; e_iss = 0; e_exe = 0; e_rts = 0; e_fin = 0; e_wb = 0; e_res = 0;
    model_outputs();
  endtask

  task automatic model_step();
    int comp, ctag, cdest, free, disp, ok, sa, sb, qa, qb;
    logic [31:0] cval, va, vb;
    if (reset) begin
      model_reset();
      return;
    end
    k++;
    comp = (m_add_busy != 0 && k == m_done) ? 1 : 0;
    ctag = m_tag; cval = m_res; cdest = m_exdest;
    free = -1;
    for (int i = 0; i < NRS; i++) if (m_busy[i] == 0 && free < 0) free = i;
    disp = -1;
    if (m_add_busy == 0)
      for (int i = 0; i < NRS; i++)
        if (m_busy[i] != 0 && m_exec[i] == 0 && m_qj[i] == 0 && m_qk[i] == 0 && disp < 0) disp = i;
    ok = (bus.issue && bus.execution_unit == 3'd0 && free >= 0) ? 1 : 0;
    e_err = (bus.issue && ok == 0) ? 1 : 0;
    sa = m_stat[bus.A_address]; sb = m_stat[bus.B_address];
    qa = sa; va = 32'd0; qb = sb; vb = 32'd0;
    if (sa == 0) va = bus.A_value;
    else if (comp != 0 && sa == ctag) begin qa = 0; va = cval; end
    if (sb == 0) vb = bus.B_value;
    else if (comp != 0 && sb == ctag) begin qb = 0; vb = cval; end

    if (comp != 0) begin
      m_busy[ctag-1] = 0; m_exec[ctag-1] = 0;
      for (int i = 0; i < NRS; i++) begin
        if (m_busy[i] != 0 && m_qj[i] == ctag) begin m_qj[i] = 0; m_vj[i] = cval; end
        if (m_busy[i] != 0 && m_qk[i] == ctag) begin m_qk[i] = 0; m_vk[i] = cval; end
      end
      if (m_stat[cdest] == ctag) m_stat[cdest] = 0;
      m_add_busy = 0;
    end
    if (disp >= 0) begin
      m_exec[disp] = 1; m_add_busy = 1; m_done = k + LAT; m_tag = disp + 1;
      m_exdest = m_dest[disp];
      m_res = alu(m_op[disp], m_vj[disp], m_vk[disp]);
    end
    if (ok != 0) begin
      m_busy[free] = 1; m_exec[free] = 0; m_op[free] = int'(bus.operation[2:0]);
      m_dest[free] = int'(bus.Dest_address);
      m_qj[free] = qa; m_vj[free] = va; m_qk[free] = qb; m_vk[free] = vb;
      m_stat[bus.Dest_address] = free + 1;
    end
    e_iss = (ok != 0) ? free + 1 : 0;
    e_exe = (disp >= 0) ? disp + 1 : 0;
    e_rts = comp;
    e_fin = (comp != 0) ? ctag : 0;
    e_res = (comp != 0) ? cval : 32'd0;
    e_wb  = (comp != 0) ? cdest : 0;
    model_outputs();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    check("issue_error", 32'(bus.issue_error), 32'(e_err));
    check("RS_issued", 32'(bus.RS_issued), 32'(e_iss));
    check("RS_executing_adder", 32'(bus.RS_executing_adder), 32'(e_exe));
    check("adder_rts", 32'(bus.adder_rts), 32'(e_rts));
    check("wb_enable", 32'(bus.wb_enable), 32'(e_rts));
    check("RS_finished", 32'(bus.RS_finished), 32'(e_fin));
    check("result_value", bus.result_value, e_res);
    check("wb_address", 32'(bus.wb_address), 32'(e_wb));
    check("adder_available", 32'(bus.adder_available), 32'(e_avail));
    check("adder_RS_available", 32'(bus.adder_RS_available), 32'(e_rsav));
    if (bus.adder_rts) begin
      seen_rts++;
      last_fin = int'(bus.RS_finished);
      last_res = bus.result_value;
    end
  endtask

  task automatic drive(input logic iss, input logic [5:0] op, input logic [2:0] unit,
                       input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
                       input logic [31:0] av, input logic [31:0] bv);
    bus.issue = iss; bus.operation = op; bus.execution_unit = unit;
    bus.Dest_address = d; bus.A_address = a; bus.B_address = b;
    bus.A_value = av; bus.B_value = bv;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 6'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
      tick();
    end
  endtask

  initial begin
    model_reset();
    last_fin = 0; last_res = 0; seen_rts = 0;
    drive(1'b0, 6'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("reset_avail", 32'(bus.adder_available), 32'd1);
    check("reset_rs_avail", 32'(bus.adder_RS_available), 32'd1);
    check("reset_rts", 32'(bus.adder_rts), 32'd0);

    // Single add: R7 = R1 + R3 = 5 + 9
    drive(1'b1, 6'd0, 3'd0, 5'd7, 5'd1, 5'd3, 32'd5, 32'd9);
    tick();
    check("add_issued", 32'(bus.RS_issued), 32'd1);
    idle(1);
    check("add_exec", 32'(bus.RS_executing_adder), 32'd1);
    idle(2);
    check("add_rts", 32'(bus.adder_rts), 32'd1);
    check("add_fin", 32'(bus.RS_finished), 32'd1);
    check("add_result", bus.result_value, 32'd14);
    check("add_wb", 32'(bus.wb_address), 32'd7);
    idle(2);

    // RAW chain: R8 = R7 - R1 must wait for tag 1 and ignore the stale A_value
    drive(1'b1, 6'd0, 3'd0, 5'd7, 5'd1, 5'd3, 32'd5, 32'd9);
    tick();
    drive(1'b1, 6'd1, 3'd0, 5'd8, 5'd7, 5'd1, 32'd99, 32'd5);
    tick();
    idle(8);
    check("raw_fin", 32'(last_fin), 32'd2);
    check("raw_result", last_res, 32'd9);

    // Fill every station behind a dependency chain, then overflow
    drive(1'b1, 6'd0, 3'd0, 5'd10, 5'd1, 5'd2, 32'd1, 32'd2);
    tick();
    drive(1'b1, 6'd0, 3'd0, 5'd11, 5'd10, 5'd1, 32'd0, 32'd1);
    tick();
    drive(1'b1, 6'd0, 3'd0, 5'd12, 5'd11, 5'd1, 32'd0, 32'd1);
    tick();
    check("full_avail", 32'(bus.adder_available), 32'd0);
    check("full_rs_avail", 32'(bus.adder_RS_available), 32'd0);
    drive(1'b1, 6'd0, 3'd0, 5'd13, 5'd1, 5'd2, 32'd1, 32'd2);
    tick();
    check("full_issue_error", 32'(bus.issue_error), 32'd1);
    check("full_no_issue", 32'(bus.RS_issued), 32'd0);
    idle(14);

    // Wrong execution unit is rejected with no allocation
    drive(1'b1, 6'd0, 3'd1, 5'd4, 5'd1, 5'd2, 32'd1, 32'd2);
    tick();
    check("unit_issue_error", 32'(bus.issue_error), 32'd1);
    check("unit_no_issue", 32'(bus.RS_issued), 32'd0);
    check("unit_rs_avail", 32'(bus.adder_RS_available), 32'd1);
    idle(2);

    // Source produced on the same edge as the issue comes from the CDB
    drive(1'b1, 6'd0, 3'd0, 5'd5, 5'd1, 5'd2, 32'd3, 32'd4);
    tick();
    idle(2);
    drive(1'b1, 6'd0, 3'd0, 5'd6, 5'd5, 5'd5, 32'd1000, 32'd1000);
    tick();
    check("bypass_first_result", bus.result_value, 32'd7);
    check("bypass_issued", 32'(bus.RS_issued), 32'd2);
    idle(1);
    check("bypass_exec_next", 32'(bus.RS_executing_adder), 32'd2);
    idle(3);
    check("bypass_fin", 32'(last_fin), 32'd2);
    check("bypass_result", last_res, 32'd14);
    idle(2);

    // Reset between dispatch and completion flushes the broadcast
    drive(1'b1, 6'd0, 3'd0, 5'd9, 5'd1, 5'd2, 32'd3, 32'd4);
    tick();
    idle(1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    seen_rts = 0;
    idle(5);
    check("flush_no_rts", 32'(seen_rts), 32'd0);
    check("flush_rs_avail", 32'(bus.adder_RS_available), 32'd1);
    check("flush_avail", 32'(bus.adder_available), 32'd1);

    // Random traffic with a small register window to force dependencies
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0,
            6'($urandom_range(0, 63)),
            ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom, $urandom);
      reset = ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0;
      tick();
    end
    reset = 1'b0;
    idle(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/adder_reservation_station.md
Name: adder_reservation_station

Overview:
- Responder side of the instruction-queue issue interface for the adder unit in the Tomasulo datapath.
- Accepts issued adder instructions into NUM_RS reservation stations and renames destinations through an internal register-status table.
- Dispatches ready stations to a single non-pipelined adder and broadcasts results on the common data bus (CDB).
- Drives the status tags (issued/executing/finished) that the queue uses to retire entries.

Parameters:
- NUM_RS, 3, number of adder reservation stations (1..6)
- DATA_WIDTH, 32, operand/result width
- NUM_REGS, 32, architectural registers (5-bit addresses)
- ADD_LATENCY, 2, cycles from dispatch to result broadcast (>=1)

Ports:
- clock  in  1  system clock, all state on posedge
- reset  in  1  synchronous, active-high
- issue  in  1  issue strobe from queue
- operation  in  6  opcode; [2:0] = ALU op
- execution_unit  in  3  target unit; accepted only if 3'b000 (ADDER)
- Dest_address  in  5  destination register
- A_address  in  5  source A register
- B_address  in  5  source B register
- A_value  in  DATA_WIDTH  register-file read data for A_address
- B_value  in  DATA_WIDTH  register-file read data for B_address
- adder_available  out  1  at least one station free
- adder_RS_available  out  6  tag of lowest free station, 0 if none
- issue_error  out  1  one-cycle pulse: issue rejected
- RS_issued  out  6  one-cycle pulse: tag just allocated
- RS_executing_adder  out  6  one-cycle pulse: tag just dispatched
- adder_rts  out  1  one-cycle pulse: CDB valid
- RS_finished  out  6  tag broadcast on CDB
- result_value  out  DATA_WIDTH  CDB data
- wb_enable  out  1  register-file write strobe (equal to adder_rts)
- wb_address  out  5  register-file write address

Behaviour:
- Tags: station i (0-based) has tag i+1; tag 0 means "none/value ready".
- Reset: all stations free, register-status table zeroed, adder idle, counter 0. Outputs after reset: adder_available=1, adder_RS_available=1, all pulses, tags, result_value, wb_* = 0. Reset mid-operation flushes everything; no broadcast follows.
- adder_available and adder_RS_available are combinational from registered busy bits. A station freed at edge E becomes advertised after E.
- Issue (edge E0, issue=1):
  - If execution_unit!=3'b000 or no station is free, pulse issue_error for one cycle with no state change.
  - Otherwise allocate the lowest free station and pulse RS_issued=tag after E0.
  - Per source: if status[src]==0, capture the src value. Else if status[src] equals the tag completing at E0, capture the CDB result. Else record Qj/Qk=status[src].
  - Then status[Dest]=new tag. Sources are read before the destination is written, so Dest==A is legal.
- Dispatch: at an edge where the adder is idle and the lowest-indexed station is busy, has Qj=Qk=0 and is not executing, latch its operands, op and dest; counter=ADD_LATENCY; pulse RS_executing_adder=tag.
- A station whose operand is captured from the CDB at edge E is dispatch-eligible at E+1 at the earliest.
- Completion: the counter decrements each cycle. At the edge where it reaches 0:
  - Compute the result.
  - Register adder_rts=1, RS_finished=tag, result_value, wb_enable=1, wb_address=dest (one cycle).
  - Free the station. Clear status[dest] only if it still equals the tag.
  - Every station with Qj/Qk==tag captures the value at that same edge.
  - The adder is idle again; next dispatch earliest at the following edge.
- ALU ops:
  - 000 add (mod 2^DATA_WIDTH)
  - 001 sub (A-B, mod 2^DATA_WIDTH)
  - 100 or
  - 101 and
  - 110 not A
  - 111 xor
  - 010/011 produce 0
- Minimum latency with ADD_LATENCY=2: issue at E0, dispatch at E1, CDB visible after E3.
- Simultaneous issue + completion + dispatch in one cycle is legal. All updates are computed from pre-edge state, except the CDB capture at issue described above.

Optional Feature:
- RS_STATS_EN: when defined, adds outputs stat_issued (16 bit), stat_rejected (16 bit) and stat_stall_cycles (16 bit).
  - stat_issued counts accepted issues.
  - stat_rejected counts issue_error pulses.
  - stat_stall_cycles counts cycles with a busy station waiting on operands while the adder is idle.
  - Counters saturate at 16'hFFFF and are cleared by reset.
- When not defined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package (tomasulo_pkg): ADDER unit code, alu_* opcodes, tag width 6, TAG_NONE=0, status masks.
- Sub-module adder_alu: combinational op/A/B -> result, reused by future units.

Test Plan:
- Reset, then issue add R7=R1+R3 with A_value=5, B_value=9 -> RS_issued=1 next cycle, RS_executing_adder=1 the cycle after, adder_rts=1 with RS_finished=1, result_value=14, wb_address=7 three cycles after issue.
- RAW chain: issue R7=R1+R3 (5+9), then R8=R7-R1 (A_value=99 stale) -> second instruction waits on tag 1, then produces 14-5=9 with RS_finished=2.
- Fill all 3 stations with the adder blocked by dependencies, then a fourth issue -> issue_error pulses, adder_available=0, adder_RS_available=0.
- Issue with execution_unit=3'b001 -> issue_error=1, no RS_issued, state unchanged.
- Issue whose source tag completes at the same edge -> operand taken from the CDB, dispatch at the next edge, correct result.
- Assert reset between dispatch and completion -> no adder_rts, all stations free, adder_RS_available=1.
